// File: rtl/fip_pkg.sv
// Shared Q16.16 fixed-point types and constants for the ray-tracing datapath.
package fip_pkg;

    typedef logic signed [31:0] fip32_t;

    localparam int     INT_SHIFT = 16;
    localparam fip32_t FIP_ONE   = 32'h0001_0000;
    localparam fip32_t FIP_MAX   = 32'h7FFF_FFFF;
    localparam fip32_t FIP_MIN   = 32'h8000_0000;

endpackage

// File: rtl/fip_32_addsub_if.sv
// Operand/result bundle for the registered Q16.16 add/subtract unit.
interface fip_32_addsub_if;
    import fip_pkg::*;

    logic   in_valid;
    logic   op;
    fip32_t x;
    fip32_t y;
    logic   out_valid;
    fip32_t result;
    logic   overflow;

    modport master (
        output in_valid, op, x, y,
        input  out_valid, result, overflow
    );

    modport slave (
        input  in_valid, op, x, y,
        output out_valid, result, overflow
    );

endinterface

// File: rtl/fip_32_addsub_core.sv
// Combinational 33-bit Q16.16 add/subtract with signed overflow detect.
// Define FIP_SAT_EN to clamp overflowed results to FIP_MAX / FIP_MIN.
module fip_32_addsub_core
    import fip_pkg::*;
(
    input  fip32_t x,
    input  fip32_t y,
    input  logic   op,
    output fip32_t result,
    output logic   overflow
);

    logic [32:0] x_ext;
    logic [32:0] y_ext;
    logic [32:0] s;

    assign x_ext = {x[31], x};
    // Subtract as x + ~y + 1 at 33 bits so y = FIP_MIN negates exactly.
    assign y_ext = op ? ~{y[31], y} : {y[31], y};
    assign s     = x_ext + y_ext + {32'd0, op};

    assign overflow = s[32] ^ s[31];

`ifdef FIP_SAT_EN
    always_comb begin
        result = s[31:0];
        if (overflow) begin
            result = s[32] ? FIP_MIN : FIP_MAX;
        end
    end
`else
    assign result = s[31:0];
`endif

endmodule

// File: rtl/fip_32_addsub.sv
// Registered Q16.16 add/subtract, one-cycle latency, one op per cycle.
// Saturation on overflow is enabled by defining FIP_SAT_EN.
module fip_32_addsub
    import fip_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    fip_32_addsub_if.slave   bus
);

    fip32_t sum_nxt;
    logic   ovf_nxt;

    fip_32_addsub_core u_core (
        .x        (bus.x),
        .y        (bus.y),
        .op       (bus.op),
        .result   (sum_nxt),
        .overflow (ovf_nxt)
    );

    // result/overflow hold their last values while in_valid is low.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bus.out_valid <= 1'b0;
            bus.result    <= '0;
            bus.overflow  <= 1'b0;
        end else begin
            bus.out_valid <= bus.in_valid;
            if (bus.in_valid) begin
                bus.result   <= sum_nxt;
                bus.overflow <= ovf_nxt;
            end
        end
    end

endmodule

// File: tb/tb_fip_32_addsub.sv
// Directed self-checking bench for fip_32_addsub (wrap or FIP_SAT_EN build).
module tb_fip_32_addsub;
    import fip_pkg::*;

    logic clk;
    logic rst;
    int   passed;
    int   total;

    fip_32_addsub_if bus ();

    fip_32_addsub dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit expired, got no finish, required finish");
        $fatal(1);
    end

    // Present one operand set on the falling edge; result is checked 1 after the next rising edge.
    task automatic drive(input logic v, input logic o, input fip32_t a, input fip32_t b);
        @(negedge clk);
        bus.in_valid = v;
        bus.op       = o;
        bus.x        = a;
        bus.y        = b;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst          = 1'b1;
        bus.in_valid = 1'b0;
        bus.op       = 1'b0;
        bus.x        = '0;
        bus.y        = '0;
        #1;
        total++;
        if (bus.out_valid !== 1'b0) $display("FAIL reset_out_valid: got %b required 0", bus.out_valid);
        else passed++;
        total++;
        if (bus.result !== 32'h0) $display("FAIL reset_result: got %h required 00000000", bus.result);
        else passed++;
        total++;
        if (bus.overflow !== 1'b0) $display("FAIL reset_overflow: got %b required 0", bus.overflow);
        else passed++;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_add();
        fip32_t exp_r;
        drive(1'b1, 1'b0, 32'h0001_0000, 32'h0001_0000);
        total++;
        if (bus.out_valid !== 1'b1) $display("FAIL add_one_valid: got %b required 1", bus.out_valid);
        else passed++;
        total++;
        if (bus.result !== 32'h0002_0000 || bus.overflow !== 1'b0)
            $display("FAIL add_one: got %h/%b required 00020000/0", bus.result, bus.overflow);
        else passed++;

        drive(1'b1, 1'b0, 32'h7FFF_FFFF, 32'h0001_0000);
`ifdef FIP_SAT_EN
        exp_r = 32'h7FFF_FFFF;
`else
        exp_r = 32'h8000_FFFF;
`endif
        total++;
        if (bus.result !== exp_r || bus.overflow !== 1'b1)
            $display("FAIL add_pos_ovf: got %h/%b required %h/1", bus.result, bus.overflow, exp_r);
        else passed++;

        drive(1'b1, 1'b0, 32'hFFFF_0000, 32'hFFFF_FFFF);
        total++;
        if (bus.result !== 32'hFFFE_FFFF || bus.overflow !== 1'b0)
            $display("FAIL add_neg: got %h/%b required fffeffff/0", bus.result, bus.overflow);
        else passed++;
    endtask

    task automatic test_sub();
        fip32_t exp_r;
        drive(1'b1, 1'b1, 32'h0002_0000, 32'h0001_0000);
        total++;
        if (bus.result !== 32'h0001_0000 || bus.overflow !== 1'b0)
            $display("FAIL sub_basic: got %h/%b required 00010000/0", bus.result, bus.overflow);
        else passed++;

        drive(1'b1, 1'b1, 32'h8000_0000, 32'h0000_0001);
`ifdef FIP_SAT_EN
        exp_r = 32'h8000_0000;
`else
        exp_r = 32'h7FFF_FFFF;
`endif
        total++;
        if (bus.result !== exp_r || bus.overflow !== 1'b1)
            $display("FAIL sub_neg_ovf: got %h/%b required %h/1", bus.result, bus.overflow, exp_r);
        else passed++;

        drive(1'b1, 1'b1, 32'h0000_0000, 32'h8000_0000);
`ifdef FIP_SAT_EN
        exp_r = 32'h7FFF_FFFF;
`else
        exp_r = 32'h8000_0000;
`endif
        total++;
        if (bus.result !== exp_r || bus.overflow !== 1'b1)
            $display("FAIL sub_min: got %h/%b required %h/1", bus.result, bus.overflow, exp_r);
        else passed++;
    endtask

    task automatic test_hold();
        drive(1'b1, 1'b0, 32'h0000_1234, 32'h0000_0001);
        drive(1'b0, 1'b0, 32'h7FFF_FFFF, 32'h7FFF_FFFF);
        total++;
        if (bus.out_valid !== 1'b0) $display("FAIL hold_valid: got %b required 0", bus.out_valid);
        else passed++;
        total++;
        if (bus.result !== 32'h0000_1235 || bus.overflow !== 1'b0)
            $display("FAIL hold_value: got %h/%b required 00001235/0", bus.result, bus.overflow);
        else passed++;
    endtask

    task automatic test_back_to_back();
        logic   ops [6];
        fip32_t xs  [6];
        fip32_t ys  [6];
        fip32_t ers [6];
        logic   eos [6];
        ops[0] = 1'b0; xs[0] = 32'h0003_0000; ys[0] = 32'h0001_8000; ers[0] = 32'h0004_8000; eos[0] = 1'b0;
        ops[1] = 1'b1; xs[1] = 32'h0003_0000; ys[1] = 32'h0001_8000; ers[1] = 32'h0001_8000; eos[1] = 1'b0;
        ops[2] = 1'b0; xs[2] = 32'h4000_0000; ys[2] = 32'h4000_0000; eos[2] = 1'b1;
        ops[3] = 1'b1; xs[3] = 32'hC000_0000; ys[3] = 32'h4000_0001; eos[3] = 1'b1;
        ops[4] = 1'b0; xs[4] = 32'hFFFF_FFFF; ys[4] = 32'h0000_0001; ers[4] = 32'h0000_0000; eos[4] = 1'b0;
        ops[5] = 1'b1; xs[5] = 32'h0000_0001; ys[5] = 32'h0000_0002; ers[5] = 32'hFFFF_FFFF; eos[5] = 1'b0;
`ifdef FIP_SAT_EN
        ers[2] = 32'h7FFF_FFFF;
        ers[3] = 32'h8000_0000;
`else
        ers[2] = 32'h8000_0000;
        ers[3] = 32'h7FFF_FFFF;
`endif
        for (int i = 0; i < 6; i++) begin
            drive(1'b1, ops[i], xs[i], ys[i]);
            total++;
            if (bus.out_valid !== 1'b1 || bus.result !== ers[i] || bus.overflow !== eos[i])
                $display("FAIL b2b_%0d: got v=%b %h/%b required v=1 %h/%b",
                         i, bus.out_valid, bus.result, bus.overflow, ers[i], eos[i]);
            else passed++;
        end
    endtask

    task automatic test_reset_midstream();
        drive(1'b1, 1'b0, 32'h4000_0000, 32'h4000_0000);
        @(negedge clk);
        bus.x = 32'h0000_0005;
        bus.y = 32'h0000_0003;
        #2;
        rst = 1'b1;
        #1;
        total++;
        if (bus.out_valid !== 1'b0 || bus.result !== 32'h0 || bus.overflow !== 1'b0)
            $display("FAIL reset_async: got v=%b %h/%b required v=0 00000000/0",
                     bus.out_valid, bus.result, bus.overflow);
        else passed++;
        @(posedge clk);
        #1;
        rst = 1'b0;
        bus.in_valid = 1'b0;
        @(posedge clk);
        #1;
        total++;
        if (bus.out_valid !== 1'b0 || bus.result !== 32'h0)
            $display("FAIL reset_release_idle: got v=%b %h required v=0 00000000", bus.out_valid, bus.result);
        else passed++;
        drive(1'b1, 1'b1, 32'h0000_0005, 32'h0000_0003);
        total++;
        if (bus.out_valid !== 1'b1 || bus.result !== 32'h0000_0002 || bus.overflow !== 1'b0)
            $display("FAIL reset_first_result: got v=%b %h/%b required v=1 00000002/0",
                     bus.out_valid, bus.result, bus.overflow);
        else passed++;
    endtask

    initial begin
        passed = 0;
        total  = 0;
        test_reset();
        test_add();
        test_sub();
        test_hold();
        test_back_to_back();
        test_reset_midstream();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
